axi_lite_req_arbiter: RTL

Round-robin arbiter that shares the single AXI-Lite master port of the PCIe-to-AXI-Lite bridge between NUM_REQ simple register-access requesters (requester 0 is the PCIe TLP decode path, others are local sequencers/debug). It accepts one request at a time from a granted requester and drives it as a complete AXI-Lite read or write. It returns read data and error status to that requester. A per-transaction timeout keeps a hung slave from locking out every requester.

---
 rtl/axi_lite_req_arbiter.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_req_arbiter
// Purpose  : Round-robin arbiter sharing one AXI-Lite master port between
//            NUM_REQ register-access requesters, with per-transaction timeout.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_req_arbiter #(
    parameter int          NUM_REQ        = 2,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic                   user_clk,
    input  logic                   user_reset,

    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [32*NUM_REQ-1:0]  req_addr,
    input  logic [32*NUM_REQ-1:0]  req_wdata,
    input  logic [4*NUM_REQ-1:0]   req_wstrb,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,

    output logic [31:0]            M_AXI_AWADDR,
    output logic                   M_AXI_AWVALID,
    input  logic                   M_AXI_AWREADY,
    output logic [31:0]            M_AXI_WDATA,
    output logic [3:0]             M_AXI_WSTRB,
    output logic                   M_AXI_WVALID,
    input  logic                   M_AXI_WREADY,
    input  logic [1:0]             M_AXI_BRESP,
    input  logic                   M_AXI_BVALID,
    output logic                   M_AXI_BREADY,

    output logic [31:0]            M_AXI_ARADDR,
    output logic                   M_AXI_ARVALID,
    input  logic                   M_AXI_ARREADY,
    input  logic [31:0]            M_AXI_RDATA,
    input  logic [1:0]             M_AXI_RRESP,
    input  logic                   M_AXI_RVALID,
    output logic                   M_AXI_RREADY
);

    localparam int c_GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TW-1:0] c_TIMER_LAST =
        c_TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [c_GW-1:0] c_LAST_RESET = c_GW'(NUM_REQ - 1);
    localparam bit c_TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [c_GW-1:0]   r_grant;
    logic [c_GW-1:0]   r_last_grant;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic              r_aw_done;
    logic              r_w_done;
    logic [c_TW-1:0]   r_timer;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic              w_found;
    logic [c_GW-1:0]   w_sel;
    logic              w_grant_now;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_active;
    logic              w_timeout;
    logic              w_abort;
    logic              w_unused;

    // Nearest pending requester after last_grant; descending scan so the closest wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[(int'(r_last_grant) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_sel   = c_GW'((int'(r_last_grant) + k) % NUM_REQ);
            end
        end
    end

    assign w_grant_now = (r_state == S_IDLE) && w_found && !user_reset;
    assign w_aw_hs     = (r_state == S_WR_ADDR) && !r_aw_done && M_AXI_AWREADY;
    assign w_w_hs      = (r_state == S_WR_ADDR) && !r_w_done && M_AXI_WREADY;
    assign w_active    = (r_state != S_IDLE) && (r_state != S_RESP);
    assign w_timeout   = c_TIMEOUT_EN && (r_timer == c_TIMER_LAST);
    assign w_unused    = ^{M_AXI_BRESP[0], M_AXI_RRESP[0]};

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A response arriving in the timeout cycle takes priority over the abort.
    always_comb begin
        w_state_next  = r_state;
        w_abort       = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_now) begin
                    w_state_next = req_write[w_sel] ? S_WR_ADDR : S_RD_ADDR;
                end
            end
            S_WR_ADDR: begin
                M_AXI_AWVALID = !r_aw_done;
                M_AXI_WVALID  = !r_w_done;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_state_next = S_WR_RESP;
                end else if (w_timeout) begin
                    w_state_next = S_RESP;
                    w_abort      = 1'b1;
                end
            end
            S_WR_RESP: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) begin
                    w_state_next = S_RESP;
                end else if (w_timeout) begin
                    w_state_next = S_RESP;
                    w_abort      = 1'b1;
                end
            end
            S_RD_ADDR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) begin
                    w_state_next = S_RD_DATA;
                end else if (w_timeout) begin
                    w_state_next = S_RESP;
                    w_abort      = 1'b1;
                end
            end
            S_RD_DATA: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) begin
                    w_state_next = S_RESP;
                end else if (w_timeout) begin
                    w_state_next = S_RESP;
                    w_abort      = 1'b1;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            r_grant      <= '0;
            r_last_grant <= c_LAST_RESET;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_timer      <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_grant_now) begin
                r_grant      <= w_sel;
                r_last_grant <= w_sel;
                r_addr       <= req_addr[int'(w_sel)*32 +: 32];
                r_wdata      <= req_wdata[int'(w_sel)*32 +: 32];
                r_wstrb      <= req_wstrb[int'(w_sel)*4 +: 4];
                r_aw_done    <= 1'b0;
                r_w_done     <= 1'b0;
                r_timer      <= '0;
            end else begin
                if (w_aw_hs) begin
                    r_aw_done <= 1'b1;
                end
                if (w_w_hs) begin
                    r_w_done <= 1'b1;
                end
                if (w_active) begin
                    r_timer <= r_timer + 1'b1;
                end
            end

            if (r_state == S_WR_RESP && M_AXI_BVALID) begin
                r_err <= M_AXI_BRESP[1];
            end else if (r_state == S_RD_DATA && M_AXI_RVALID) begin
                r_rdata <= M_AXI_RDATA;
                r_err   <= M_AXI_RRESP[1];
            end else if (w_abort) begin
                r_rdata <= ERR_RDATA;
                r_err   <= 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_grant_now && (w_sel == c_GW'(i));
            rsp_valid[i] = (r_state == S_RESP) && (r_grant == c_GW'(i));
        end
    end

    assign rsp_rdata    = r_rdata;
    assign rsp_err      = r_err;
    assign M_AXI_AWADDR = r_addr;
    assign M_AXI_ARADDR = r_addr;
    assign M_AXI_WDATA  = r_wdata;
    assign M_AXI_WSTRB  = r_wstrb;

endmodule
`default_nettype wire
